// File: rtl/gate_bit_parity_checker_if.sv
// Bus bundle for the serial gate-bit parity checker: serial input side plus decoded word outputs.
// The master drives the serial link; the slave is the checker itself.
interface gate_bit_parity_checker_if #(
  parameter int unsigned C_WIDTH         = 8,
  parameter int unsigned C_ERR_CNT_WIDTH = 8
) ();
  logic                       ce;
  logic                       sclr;
  logic                       d;
  logic                       d_valid;
  logic                       sof;
  logic [C_WIDTH-1:0]         q_data;
  logic                       q_valid;
  logic                       par_err;
  logic [C_ERR_CNT_WIDTH-1:0] err_cnt;
  logic                       frame_abort;
  logic                       busy;

  modport master (
    output ce, sclr, d, d_valid, sof,
    input  q_data, q_valid, par_err, err_cnt, frame_abort, busy
  );

  modport slave (
    input  ce, sclr, d, d_valid, sof,
    output q_data, q_valid, par_err, err_cnt, frame_abort, busy
  );
endinterface

// File: rtl/gate_bit_parity_checker.sv
// Deserialises an LSB-first frame of C_WIDTH data bits plus one parity bit, rechecks the
// XOR/XNOR reduction with the optional inversion mask and keeps a saturating error count.
module gate_bit_parity_checker #(
  parameter int unsigned       C_WIDTH          = 8,
  parameter int unsigned       C_GATE_TYPE      = 4,
  parameter logic [8*32-1:0]   C_INPUT_INV_MASK = "",
  parameter bit                C_HAS_CE         = 1'b0,
  parameter int unsigned       C_ERR_CNT_WIDTH  = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  gate_bit_parity_checker_if.slave bus
);

  localparam int unsigned CntW = $clog2(C_WIDTH);

  // Mask string is right-justified: byte i holds the character for data bit i.
  function automatic logic [C_WIDTH-1:0] decode_mask();
    logic [C_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < int'(C_WIDTH); i++) begin
      m[i] = (C_INPUT_INV_MASK[8*i +: 8] == 8'h31);
    end
    return m;
  endfunction

  function automatic bit mask_legal();
    logic [7:0] ch;
    for (int i = 0; i < 32; i++) begin
      ch = C_INPUT_INV_MASK[8*i +: 8];
      if (i >= int'(C_WIDTH) && ch != 8'h00) return 1'b0;
      if (ch != 8'h00 && ch != 8'h30 && ch != 8'h31) return 1'b0;
    end
    return 1'b1;
  endfunction

  localparam logic [C_WIDTH-1:0] InvMask = decode_mask();

  if (C_GATE_TYPE != 4 && C_GATE_TYPE != 5) begin : g_bad_gate
    $fatal(1, "gate_bit_parity_checker: C_GATE_TYPE must be 4 (XOR) or 5 (XNOR)");
  end
  if (C_WIDTH < 2 || C_WIDTH > 32) begin : g_bad_width
    $fatal(1, "gate_bit_parity_checker: C_WIDTH must be in 2..32");
  end
  if (!mask_legal()) begin : g_bad_mask
    $fatal(1, "gate_bit_parity_checker: C_INPUT_INV_MASK must hold only '0'/'1'");
  end

  typedef enum logic [1:0] {StIdle, StData, StParity} state_e;

  state_e                     state_q;
  logic [CntW-1:0]            cnt_q;
  logic [C_WIDTH-1:0]         shift_q;
  logic [C_WIDTH-1:0]         q_data_q;
  logic                       q_valid_q;
  logic                       par_err_q;
  logic [C_ERR_CNT_WIDTH-1:0] err_cnt_q;
  logic                       frame_abort_q;

  logic ce_eff;
  logic reduce_r;
  logic mismatch;

  assign ce_eff = C_HAS_CE ? bus.ce : 1'b1;

  always_comb begin
    reduce_r = (^(shift_q ^ InvMask)) ^ bus.d;
    mismatch = (C_GATE_TYPE == 5) ? ~reduce_r : reduce_r;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      shift_q       <= '0;
      q_data_q      <= '0;
      q_valid_q     <= 1'b0;
      par_err_q     <= 1'b0;
      err_cnt_q     <= '0;
      frame_abort_q <= 1'b0;
    end else if (!ce_eff) begin
      q_valid_q     <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      q_valid_q     <= 1'b0;
      frame_abort_q <= 1'b0;
      if (bus.sclr) begin
        state_q   <= StIdle;
        cnt_q     <= '0;
        shift_q   <= '0;
        q_data_q  <= '0;
        par_err_q <= 1'b0;
        err_cnt_q <= '0;
      end else if (bus.d_valid) begin
        if (bus.sof) begin
          // A new frame always restarts, abandoning any partial one.
          frame_abort_q <= (state_q != StIdle);
          shift_q       <= {{(C_WIDTH-1){1'b0}}, bus.d};
          cnt_q         <= CntW'(1);
          state_q       <= StData;
        end else begin
          unique case (state_q)
            StData: begin
              shift_q[cnt_q] <= bus.d;
              cnt_q          <= cnt_q + CntW'(1);
              if (cnt_q == CntW'(C_WIDTH - 1)) state_q <= StParity;
            end
            StParity: begin
              q_data_q  <= shift_q;
              par_err_q <= mismatch;
              q_valid_q <= 1'b1;
              if (mismatch && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + C_ERR_CNT_WIDTH'(1);
              cnt_q     <= '0;
              state_q   <= StIdle;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.q_data      = q_data_q;
  assign bus.q_valid     = q_valid_q;
  assign bus.par_err     = par_err_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.frame_abort = frame_abort_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: tb/tb_gate_bit_parity_checker.sv
// Drives three differently configured checkers from one serial stream and compares each
// against a frame-level reference model every cycle.
module tb_gate_bit_parity_checker;

  localparam int       W       = 8;
  localparam int       GATE[3] = '{4, 5, 4};
  localparam logic [7:0] MASK[3] = '{8'h00, 8'h00, 8'h01};
  localparam bit       HASCE[3] = '{1'b1, 1'b0, 1'b1};
  localparam int       ECMAX[3] = '{3, 255, 255};

  logic clk, rst_n;
  logic ce, sclr, d, dv, sof;
  int   errors = 0;
  int   checks = 0;

  gate_bit_parity_checker_if #(.C_WIDTH(8), .C_ERR_CNT_WIDTH(2)) if0 ();
  gate_bit_parity_checker_if #(.C_WIDTH(8), .C_ERR_CNT_WIDTH(8)) if1 ();
  gate_bit_parity_checker_if #(.C_WIDTH(8), .C_ERR_CNT_WIDTH(8)) if2 ();

  assign if0.ce = ce;  assign if0.sclr = sclr;  assign if0.d = d;
  assign if0.d_valid = dv;  assign if0.sof = sof;
  assign if1.ce = ce;  assign if1.sclr = sclr;  assign if1.d = d;
  assign if1.d_valid = dv;  assign if1.sof = sof;
  assign if2.ce = ce;  assign if2.sclr = sclr;  assign if2.d = d;
  assign if2.d_valid = dv;  assign if2.sof = sof;

  gate_bit_parity_checker #(
    .C_WIDTH(8), .C_GATE_TYPE(4), .C_INPUT_INV_MASK(""), .C_HAS_CE(1'b1), .C_ERR_CNT_WIDTH(2)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));

  gate_bit_parity_checker #(
    .C_WIDTH(8), .C_GATE_TYPE(5), .C_INPUT_INV_MASK(""), .C_HAS_CE(1'b0), .C_ERR_CNT_WIDTH(8)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  gate_bit_parity_checker #(
    .C_WIDTH(8), .C_GATE_TYPE(4), .C_INPUT_INV_MASK("00000001"), .C_HAS_CE(1'b1),
    .C_ERR_CNT_WIDTH(8)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  logic       o_qv[3], o_ab[3], o_pe[3], o_busy[3];
  logic [7:0] o_qd[3];
  logic [31:0] o_ec[3];

  assign o_qv[0] = if0.q_valid;  assign o_ab[0] = if0.frame_abort;  assign o_pe[0] = if0.par_err;
  assign o_busy[0] = if0.busy;   assign o_qd[0] = if0.q_data;       assign o_ec[0] = 32'(if0.err_cnt);
  assign o_qv[1] = if1.q_valid;  assign o_ab[1] = if1.frame_abort;  assign o_pe[1] = if1.par_err;
  assign o_busy[1] = if1.busy;   assign o_qd[1] = if1.q_data;       assign o_ec[1] = 32'(if1.err_cnt);
  assign o_qv[2] = if2.q_valid;  assign o_ab[2] = if2.frame_abort;  assign o_pe[2] = if2.par_err;
  assign o_busy[2] = if2.busy;   assign o_qd[2] = if2.q_data;       assign o_ec[2] = 32'(if2.err_cnt);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: counts collected bits per frame and decides parity by popcount.
  bit         m_qv[3], m_ab[3], m_pe[3], m_in[3];
  logic [7:0] m_qd[3], m_dat[3];
  int         m_n[3], m_ec[3];

  task automatic model_reset(int k);
    m_qv[k] = 0; m_ab[k] = 0; m_pe[k] = 0; m_in[k] = 0;
    m_qd[k] = '0; m_dat[k] = '0; m_n[k] = 0; m_ec[k] = 0;
  endtask

  task automatic model_step(int k);
    int  ones;
    bit  mis;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    m_qv[k] = 0;
    m_ab[k] = 0;
    if (HASCE[k] && !ce) return;
    if (sclr) begin
      model_reset(k);
      return;
    end
    if (!dv) return;
    if (sof) begin
      m_ab[k]  = m_in[k];
      m_in[k]  = 1;
      m_n[k]   = 1;
      m_dat[k] = {7'b0, d};
    end else if (m_in[k]) begin
      if (m_n[k] < W) begin
        m_dat[k][m_n[k][2:0]] = d;
        m_n[k]++;
      end else begin
        ones    = $countones(m_dat[k] ^ MASK[k]) + int'(d);
        mis     = (GATE[k] == 5) ? (ones % 2 == 0) : (ones % 2 == 1);
        m_qd[k] = m_dat[k];
        m_pe[k] = mis;
        m_qv[k] = 1;
        if (mis && m_ec[k] < ECMAX[k]) m_ec[k]++;
        m_in[k] = 0;
        m_n[k]  = 0;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) model_reset(k);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  task automatic chk(int k, string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL u%0d %s got %0h expected %0h at %0t", k, nm, act, exp, $time);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk(k, "q_valid", 32'(o_qv[k]), 32'(m_qv[k]));
        chk(k, "frame_abort", 32'(o_ab[k]), 32'(m_ab[k]));
        chk(k, "par_err", 32'(o_pe[k]), 32'(m_pe[k]));
        chk(k, "busy", 32'(o_busy[k]), 32'(m_in[k]));
        chk(k, "q_data", 32'(o_qd[k]), 32'(m_qd[k]));
        chk(k, "err_cnt", o_ec[k], 32'(m_ec[k]));
      end
    end
  end

  task automatic lit(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL lit %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send_bit(logic b, logic s);
    d = b; dv = 1'b1; sof = s;
    @(negedge clk);
    dv = 1'b0; sof = 1'b0;
  endtask

  task automatic send_frame(logic [7:0] v, logic p);
    for (int i = 0; i < W; i++) send_bit(v[i], i == 0);
    send_bit(p, 1'b0);
  endtask

  initial begin
    logic [7:0] v;
    rst_n = 1'b0; ce = 1'b1; sclr = 1'b0; d = 1'b0; dv = 1'b0; sof = 1'b0;
    repeat (3) @(negedge clk);
    lit("reset q_data", 32'(o_qd[0]), 32'h0);
    lit("reset err_cnt", o_ec[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // 0xA5 has four ones: XOR clean with P=0, XNOR and masked-XOR both flag it.
    send_frame(8'hA5, 1'b0);
    lit("f0 q_valid", 32'(o_qv[0]), 32'h1);
    lit("f0 q_data", 32'(o_qd[0]), 32'hA5);
    lit("f0 xor par_err", 32'(o_pe[0]), 32'h0);
    lit("f0 xnor par_err", 32'(o_pe[1]), 32'h1);
    lit("f0 mask par_err", 32'(o_pe[2]), 32'h1);
    lit("f0 mask q_data", 32'(o_qd[2]), 32'hA5);
    lit("f0 err_cnt", o_ec[0], 32'h0);

    // Five back-to-back errored frames for the XOR unit; its 2-bit counter saturates at 3.
    for (int f = 0; f < 5; f++) begin
      send_frame(8'hA5, 1'b1);
      lit("b2b q_valid", 32'(o_qv[0]), 32'h1);
      lit("b2b xor par_err", 32'(o_pe[0]), 32'h1);
      lit("b2b err_cnt", o_ec[0], (f < 2) ? 32'(f + 1) : 32'h3);
    end
    lit("xnor par_err P=1", 32'(o_pe[1]), 32'h0);
    lit("mask par_err P=1", 32'(o_pe[2]), 32'h0);
    lit("xnor err_cnt", o_ec[1], 32'h1);

    // Abandon a frame after four bits, then a complete 0x3C.
    for (int i = 0; i < 4; i++) send_bit(1'b1, i == 0);
    v = 8'h3C;
    send_bit(v[0], 1'b1);
    lit("abort pulse", 32'(o_ab[0]), 32'h1);
    for (int i = 1; i < W; i++) send_bit(v[i], 1'b0);
    send_bit(1'b0, 1'b0);
    lit("3C q_valid", 32'(o_qv[0]), 32'h1);
    lit("3C q_data", 32'(o_qd[0]), 32'h3C);
    lit("3C par_err", 32'(o_pe[0]), 32'h0);

    // Asynchronous reset mid-frame clears outputs without waiting for a clock.
    for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
    #3 rst_n = 1'b0;
    #1;
    lit("areset busy", 32'(o_busy[0]), 32'h0);
    lit("areset q_data", 32'(o_qd[0]), 32'h0);
    lit("areset err_cnt", o_ec[0], 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'hA5, 1'b0);
    lit("post-reset q_data", 32'(o_qd[0]), 32'hA5);
    lit("post-reset par_err", 32'(o_pe[0]), 32'h0);

    // Clock enable low mid-frame with garbage offered on the link.
    v = 8'h5A;
    for (int i = 0; i < 4; i++) send_bit(v[i], i == 0);
    ce = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(1)), 1'b0);
    ce = 1'b1;
    for (int i = 4; i < W; i++) send_bit(v[i], 1'b0);
    send_bit(1'b0, 1'b0);
    lit("ce q_valid", 32'(o_qv[0]), 32'h1);
    lit("ce q_data", 32'(o_qd[0]), 32'h5A);
    lit("ce par_err", 32'(o_pe[0]), 32'h0);

    // Synchronous clear while waiting for the parity bit.
    for (int i = 0; i < W; i++) send_bit(v[i], i == 0);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    lit("sclr busy", 32'(o_busy[0]), 32'h0);
    lit("sclr q_valid", 32'(o_qv[0]), 32'h0);
    lit("sclr q_data", 32'(o_qd[0]), 32'h0);
    send_bit(1'b1, 1'b0);
    lit("sclr dropped parity", 32'(o_qv[0]), 32'h0);

    // Random traffic; the per-cycle compare process does the checking.
    for (int c = 0; c < 4000; c++) begin
      d    = 1'($urandom_range(1));
      dv   = ($urandom_range(3) != 0);
      sof  = ($urandom_range(14) == 0);
      ce   = ($urandom_range(9) != 0);
      sclr = ($urandom_range(199) == 0);
      if ($urandom_range(799) == 0) begin
        #3 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    dv = 1'b0; sof = 1'b0; sclr = 1'b0; ce = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
